// File: rtl/bcd_to_bin_seq_if.sv
// bcd_to_bin_seq_if: start/busy/done handshake and data bus for the BCD-to-binary converter
//   master: drives start, bcd_in; observes busy, done, data_out, overflow, error
//   slave : the converter side
interface bcd_to_bin_seq_if;
    logic        start;
    logic [11:0] bcd_in;
    logic        busy;
    logic        done;
    logic [7:0]  data_out;
    logic        overflow;
    logic        error;
    modport master (output start, bcd_in, input busy, done, data_out, overflow, error);
    modport slave  (input start, bcd_in, output busy, done, data_out, overflow, error);
endinterface

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: iterative reverse double-dabble, 3-digit packed BCD to 8-bit binary
//   clock    : system clock, rising edge
//   reset    : synchronous active-high reset
//   bus      : start/bcd_in in; busy/done/data_out/overflow/error out
//   SATURATE : 1 -> values above 255 give 8'hFF, 0 -> low 8 bits
module bcd_to_bin_seq #(
    parameter bit SATURATE = 1'b1
) (
    input logic              clock,
    input logic              reset,
    bcd_to_bin_seq_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  r_state;
    logic [21:0] r_s;
    logic [3:0]  r_cnt;
    logic [7:0]  r_data_out;
    logic        r_overflow;
    logic        r_error;

    logic [21:0] w_shift;
    logic [21:0] w_next_s;
    logic        w_bad;
    logic        w_accept;
    logic [9:0]  w_res;
    logic        w_ovf;

    function automatic logic [3:0] fix(input logic [3:0] d);
        return (d >= 4'd8) ? d - 4'd3 : d;
    endfunction

    // Undo the x2 of the digit below: a digit that received a carried-in bit is >= 8
    assign w_shift  = r_s >> 1;
    assign w_next_s = {fix(w_shift[21:18]), fix(w_shift[17:14]), fix(w_shift[13:10]), w_shift[9:0]};
    assign w_bad    = (r_s[21:18] > 4'd9) || (r_s[17:14] > 4'd9) || (r_s[13:10] > 4'd9);
    assign w_accept = bus.start && (r_state == IDLE || r_state == DONE);
    assign w_res    = w_next_s[9:0];
    assign w_ovf    = w_res > 10'd255;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_s        <= '0;
            r_cnt      <= '0;
            r_data_out <= '0;
            r_overflow <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            case (r_state)
                CHECK: begin
                    r_state <= w_bad ? DONE : SHIFT;
                    if (w_bad) begin
                        r_error    <= 1'b1;
                        r_overflow <= 1'b0;
                        r_data_out <= 8'h00;
                    end
                end
                SHIFT: begin
                    r_s   <= w_next_s;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd9) begin
                        r_state    <= DONE;
                        r_error    <= 1'b0;
                        r_overflow <= w_ovf;
                        r_data_out <= (w_ovf && SATURATE) ? 8'hFF : w_res[7:0];
                    end
                end
                default: begin
                    r_state <= w_accept ? CHECK : IDLE;
                    if (w_accept) begin
                        r_s   <= {bus.bcd_in, 10'b0};
                        r_cnt <= '0;
                    end
                end
            endcase
        end
    end

    assign bus.busy     = (r_state == CHECK) || (r_state == SHIFT);
    assign bus.done     = (r_state == DONE);
    assign bus.data_out = r_data_out;
    assign bus.overflow = r_overflow;
    assign bus.error    = r_error;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: directed self-checking bench, SATURATE=1 and SATURATE=0 instances in lockstep
module tb_bcd_to_bin_seq;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] bcd   = 12'h000;
    int          checks = 0;
    int          errors = 0;

    bcd_to_bin_seq_if bus1 ();
    bcd_to_bin_seq_if bus0 ();

    assign bus1.start  = start;
    assign bus1.bcd_in = bcd;
    assign bus0.start  = start;
    assign bus0.bcd_in = bcd;

    bcd_to_bin_seq #(.SATURATE(1'b1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
    bcd_to_bin_seq #(.SATURATE(1'b0)) dut0 (.clock(clock), .reset(reset), .bus(bus0));

    always #5 clock = ~clock;

    task automatic run(input logic [11:0] v, output int lat, output int bz);
        start = 1'b1;
        bcd   = v;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        lat   = -1;
        bz    = 0;
        for (int k = 1; k <= 40; k++) begin
            if (bus1.done) begin
                lat = k;
                break;
            end
            if (bus1.busy) bz++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if ({bus1.busy, bus1.done, bus1.data_out, bus1.overflow, bus1.error} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got %h want 000", {bus1.busy, bus1.done, bus1.data_out, bus1.overflow, bus1.error});
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic();
        int lat, bz;
        run(12'h255, lat, bz);
        checks++;
        if (lat !== 12) begin errors++; $display("FAIL basic_latency got %0d want 12", lat); end
        checks++;
        if (bz !== 11) begin errors++; $display("FAIL basic_busy_cycles got %0d want 11", bz); end
        checks++;
        if ({bus1.data_out, bus1.overflow, bus1.error} !== 10'b1111_1111_00) begin
            errors++;
            $display("FAIL basic_255 got data=%h ovf=%b err=%b want data=ff ovf=0 err=0", bus1.data_out, bus1.overflow, bus1.error);
        end
        @(negedge clock);
        checks++;
        if (bus1.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", bus1.done); end
    endtask

    task automatic test_values();
        logic [11:0] vin [3] = '{12'h000, 12'h128, 12'h037};
        logic [7:0]  vexp[3] = '{8'h00, 8'h80, 8'h25};
        int lat, bz;
        for (int i = 0; i < 3; i++) begin
            run(vin[i], lat, bz);
            checks++;
            if (lat !== 12 || bus1.data_out !== vexp[i] || bus1.overflow !== 1'b0 || bus1.error !== 1'b0) begin
                errors++;
                $display("FAIL value_%h got lat=%0d data=%h ovf=%b err=%b want lat=12 data=%h ovf=0 err=0",
                         vin[i], lat, bus1.data_out, bus1.overflow, bus1.error, vexp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, bz;
        run(12'h037, lat, bz);
        run(12'h128, lat, bz);
        checks++;
        if (lat !== 12 || bus1.data_out !== 8'h80) begin
            errors++;
            $display("FAIL b2b_second got lat=%0d data=%h want lat=12 data=80", lat, bus1.data_out);
        end
    endtask

    task automatic test_saturate();
        int lat, bz;
        run(12'h999, lat, bz);
        checks++;
        if (lat !== 12 || bus1.data_out !== 8'hFF || bus1.overflow !== 1'b1) begin
            errors++;
            $display("FAIL sat1_999 got lat=%0d data=%h ovf=%b want lat=12 data=ff ovf=1", lat, bus1.data_out, bus1.overflow);
        end
        checks++;
        if (bus0.done !== 1'b1 || bus0.data_out !== 8'hE7 || bus0.overflow !== 1'b1) begin
            errors++;
            $display("FAIL sat0_999 got done=%b data=%h ovf=%b want done=1 data=e7 ovf=1", bus0.done, bus0.data_out, bus0.overflow);
        end
    endtask

    task automatic test_error();
        int lat, bz;
        run(12'h1A5, lat, bz);
        checks++;
        if (lat !== 2 || bus1.error !== 1'b1 || bus1.data_out !== 8'h00 || bus1.overflow !== 1'b0) begin
            errors++;
            $display("FAIL error_1a5 got lat=%0d err=%b data=%h ovf=%b want lat=2 err=1 data=00 ovf=0",
                     lat, bus1.error, bus1.data_out, bus1.overflow);
        end
        run(12'h042, lat, bz);
        checks++;
        if (lat !== 12 || bus1.error !== 1'b0 || bus1.data_out !== 8'h2A) begin
            errors++;
            $display("FAIL after_error_042 got lat=%0d err=%b data=%h want lat=12 err=0 data=2a", lat, bus1.error, bus1.data_out);
        end
    endtask

    task automatic test_ignore_busy();
        int lat = -1;
        int extra = 0;
        start = 1'b1;
        bcd   = 12'h100;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        start = 1'b1;
        bcd   = 12'h200;
        @(negedge clock);
        start = 1'b0;
        bcd   = 12'h999;
        for (int k = 5; k <= 40; k++) begin
            if (bus1.done) begin
                lat = k;
                break;
            end
            @(negedge clock);
        end
        checks++;
        if (lat !== 12 || bus1.data_out !== 8'h64) begin
            errors++;
            $display("FAIL ignore_busy got lat=%0d data=%h want lat=12 data=64", lat, bus1.data_out);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (bus1.done) extra++;
        end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL ignore_single_done got %0d extra dones want 0", extra); end
    endtask

    task automatic test_abort();
        int lat, bz;
        int seen = 0;
        start = 1'b1;
        bcd   = 12'h250;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if ({bus1.busy, bus1.done, bus1.data_out, bus1.overflow, bus1.error} !== 12'h000) begin
            errors++;
            $display("FAIL abort_outputs got %h want 000", {bus1.busy, bus1.done, bus1.data_out, bus1.overflow, bus1.error});
        end
        for (int k = 0; k < 20; k++) begin
            if (bus1.done) seen++;
            @(negedge clock);
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d dones want 0", seen); end
        run(12'h007, lat, bz);
        checks++;
        if (lat !== 12 || bus1.data_out !== 8'h07 || bus1.error !== 1'b0) begin
            errors++;
            $display("FAIL abort_restart got lat=%0d data=%h err=%b want lat=12 data=07 err=0", lat, bus1.data_out, bus1.error);
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_basic();
        test_values();
        test_back_to_back();
        test_saturate();
        test_error();
        test_ignore_busy();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
Sequential 3-digit BCD-to-binary converter. It performs the inverse of the display-path binary-to-BCD conversion. Decimal values entered as packed BCD (keypad or UART ASCII digits after masking) are converted to an 8-bit binary byte for the UART transmit path. The conversion uses an iterative reverse double-dabble (shift-right, subtract-3) with a start/busy/done handshake.

Parameters:
SATURATE, 1, on overflow (value > 255): 1 = data_out forced to 8'hFF; 0 = data_out = low 8 bits of result.

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request conversion; sampled only when busy=0
bcd_in  input  12  packed BCD: [11:8] hundreds, [7:4] tens, [3:0] units
busy  output  1  high while conversion in progress
done  output  1  single-cycle pulse: data_out/error/overflow valid and updated
data_out  output  8  binary result, held until next done
overflow  output  1  value > 255, held with data_out
error  output  1  a digit > 9 was present, held with data_out

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clock, reset).
- Reset: state=IDLE; busy=0, done=0, data_out=8'h00, overflow=0, error=0; internal shift register and iteration counter cleared. Reset overrides everything, including mid-conversion; the aborted conversion produces no done.
- Internal 22-bit register S = {B[11:0], R[9:0]}. 10 result bits cover the maximum value 999.
- FSM states: IDLE, CHECK, SHIFT, DONE.
- IDLE/DONE with start=1 on edge N: S <= {bcd_in, 10'b0}, cnt <= 0, go to CHECK. busy=1 from cycle N+1.
- CHECK (1 cycle): if any of the three BCD digits > 9 -> go to DONE with error=1, overflow=0, data_out=8'h00. Otherwise go to SHIFT.
- SHIFT (10 cycles, cnt 0..9): each cycle S <= S >> 1 (zero into MSB). Then, in the same cycle, each 4-bit digit field of the shifted B that is >= 8 has 3 subtracted. Correction is combinational on the shifted value and registered together with it. After cnt=9, go to DONE.
- On entering DONE from SHIFT: result = R (10 bits); overflow = (result > 255); data_out = overflow ? (SATURATE ? 8'hFF : result[7:0]) : result[7:0]; error=0.
- DONE (1 cycle): done=1, busy=0. Next state is IDLE, or CHECK if start=1 in this cycle (back-to-back accepted).
- Latency: valid conversion with start at edge N -> done high in cycle N+12. Invalid digit -> done high in cycle N+2.
- start while busy=1 is ignored. bcd_in is captured at start and later changes have no effect.
- data_out/overflow/error change only on the cycle done rises (or on reset).
- done is never high for two consecutive cycles unless a new conversion completes. The minimum gap is 2 cycles for the error path.

Test Plan:
- After reset, bcd_in=12'h255, start pulse at edge N -> busy=1 N+1..N+11; done=1 at N+12; data_out=8'hFF, overflow=0, error=0.
- bcd_in=12'h000 -> data_out=8'h00. bcd_in=12'h128 -> 8'h80. bcd_in=12'h037 -> 8'h25. Run back-to-back with start asserted during DONE; the second done arrives 12 cycles after the first.
- bcd_in=12'h999: SATURATE=1 -> data_out=8'hFF, overflow=1. SATURATE=0 -> data_out=8'hE7, overflow=1.
- bcd_in=12'h1A5 -> done at N+2, error=1, data_out=8'h00, overflow=0. A following 12'h042 -> data_out=8'h2A, error=0.
- Start 12'h100, then pulse start with 12'h200 and change bcd_in during busy -> both ignored; data_out=8'h64, exactly one done.
- Start 12'h250, assert reset at N+6 for one cycle -> all outputs zero, no done for 20 cycles. A fresh start with 12'h007 -> data_out=8'h07 at start+12.
